// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer initiator.
// Holds the FSM state type and the default bus/margin widths.
package timer_pkg;

  localparam int SEC_W_DEFAULT     = 10;
  localparam int WD_MARGIN_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_TOUT
  } state_e;

endpackage

// File: rtl/wd_counter.sv
// Watchdog for the timer initiator: clearable up-counter
// that flags when its count reaches a supplied limit.
module wd_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == limit);

endmodule

// File: rtl/timer_initiator.sv
// Launches one timed interval on an external counter and
// waits for its completion, with a watchdog for a silent counter.
module timer_initiator
  import timer_pkg::*;
#(
  parameter int SEC_W     = SEC_W_DEFAULT,
  parameter int WD_MARGIN = WD_MARGIN_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [SEC_W-1:0] req_seconds,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             start,
  output logic [SEC_W-1:0] counterSeconds,
  input  logic             signal
);

  state_e           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [SEC_W:0]   wd_limit;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_hit;

  // One extra bit so duration plus margin never wraps
  assign wd_limit = {1'b0, secs_q} + (SEC_W+1)'(WD_MARGIN);

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_seconds != '0) begin
            secs_d  = req_seconds;
            wd_clr  = 1'b1;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (signal) begin
          state_d = ST_DONE;
        end else if (wd_hit) begin
          state_d = ST_TOUT;
        end else begin
          wd_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_TOUT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      secs_q  <= '0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
    end
  end

  wd_counter #(
    .W(SEC_W + 1)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clr),
    .enable (wd_en),
    .limit  (wd_limit),
    .hit    (wd_hit)
  );

  assign busy           = (state_q != ST_IDLE);
  assign start          = (state_q == ST_LAUNCH);
  assign done           = (state_q == ST_DONE);
  assign timeout        = (state_q == ST_TOUT);
  assign counterSeconds = secs_q;

endmodule
